// File: rtl/sub_array_pkg.sv
// sub_array_pkg: FSM state type, flat-index mapping helpers and the parameter check
// shared by the sub-array flatten and stream packer blocks.
`define SUB_ARRAY_PARAM_CHECK(R, C, S, B) \
    if (((((R) * (C)) % (B)) != 0) || ((S) > (R)) || ((S) < 1)) begin : g_param_err \
        $fatal(1, "sub_array: ROWS*COLS must be a multiple of BEAT_ELEMS and SUB_ROWS must be in 1..ROWS"); \
    end

package sub_array_pkg;

    typedef enum logic [0:0] {IDLE, STREAM} state_t;

    // Row of flat element k: leading SUB_ROWS rows first (column-major), then the rest.
    function automatic int flat_row(input int k, input int rows, input int cols, input int sub_rows);
        int rest;
        rest = rows - sub_rows;
        if (k < cols * sub_rows) return k % sub_rows;
        if (rest == 0) return 0;
        return sub_rows + (k - cols * sub_rows) % rest;
    endfunction

    function automatic int flat_col(input int k, input int rows, input int cols, input int sub_rows);
        int rest;
        rest = rows - sub_rows;
        if (k < cols * sub_rows) return k / sub_rows;
        if (rest == 0) return 0;
        return (k - cols * sub_rows) / rest;
    endfunction

endpackage

// File: rtl/sub_array_flatten.sv
// sub_array_flatten: combinational reorder of a ROWS x COLS array into the flat
// sub-array-order vector (element 0 at the LSBs).
module sub_array_flatten
    import sub_array_pkg::*;
#(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int SUB_ROWS  = 4
) (
    input  logic [BIT_WIDTH-1:0]           i_arr [ROWS-1:0][COLS-1:0],
    output logic [ROWS*COLS*BIT_WIDTH-1:0] o_flat
);

    for (genvar k = 0; k < ROWS * COLS; k++) begin : g_elem
        localparam int R = flat_row(k, ROWS, COLS, SUB_ROWS);
        localparam int C = flat_col(k, ROWS, COLS, SUB_ROWS);
        assign o_flat[k*BIT_WIDTH +: BIT_WIDTH] = i_arr[R][C];
    end

endmodule

// File: rtl/sub_array_stream_packer.sv
// sub_array_stream_packer: captures one array and streams it as BEAT_ELEMS-element beats
// in sub-array order. Define SUB_PACKER_OVERLAP_EN to capture the next array on the last beat.
module sub_array_stream_packer
    import sub_array_pkg::*;
#(
    parameter int BIT_WIDTH  = 4,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int SUB_ROWS   = 4,
    parameter int BEAT_ELEMS = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [BIT_WIDTH-1:0]            in [ROWS-1:0][COLS-1:0],
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [BEAT_ELEMS*BIT_WIDTH-1:0] out_data,
    output logic                            out_last
);

    localparam int NUM_BEATS = ROWS * COLS / BEAT_ELEMS;
    localparam int BEAT_W    = BEAT_ELEMS * BIT_WIDTH;
    localparam int FLAT_W    = ROWS * COLS * BIT_WIDTH;
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    `SUB_ARRAY_PARAM_CHECK(ROWS, COLS, SUB_ROWS, BEAT_ELEMS)

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_beat_cnt, w_cnt_nxt;
    logic [FLAT_W-1:0]  r_flat, w_flat;
    logic               w_cap, w_fire;

    sub_array_flatten #(
        .BIT_WIDTH(BIT_WIDTH),
        .ROWS     (ROWS),
        .COLS     (COLS),
        .SUB_ROWS (SUB_ROWS)
    ) u_flatten (
        .i_arr (in),
        .o_flat(w_flat)
    );

    assign out_valid = (r_state == STREAM);
    assign out_last  = out_valid && (r_beat_cnt == LAST_BEAT);
    assign out_data  = r_flat[r_beat_cnt * BEAT_W +: BEAT_W];
`ifdef SUB_PACKER_OVERLAP_EN
    assign in_ready  = (r_state == IDLE) || (out_ready && out_last);
`else
    assign in_ready  = (r_state == IDLE);
`endif
    assign w_cap     = in_valid && in_ready;
    assign w_fire    = out_valid && out_ready;

    // A capture always restarts at beat 0, including one overlapping the last beat.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_beat_cnt;
        w_state_nxt = (w_cap || (w_fire && !out_last)) ? STREAM : (w_fire ? IDLE : r_state);
        w_cnt_nxt   = (w_cap || (w_fire && out_last)) ? '0 : (w_fire ? r_beat_cnt + 1'b1 : r_beat_cnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_flat     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_cnt_nxt;
            if (w_cap) r_flat <= w_flat;
        end
    end

endmodule

// File: tb/tb_sub_array_stream_packer.sv
// tb_sub_array_stream_packer: three packers (SUB_ROWS 4, 1, 8) on shared stimulus, checked
// against a queue-based reference ordering and an unpacking round trip.
module tb_sub_array_stream_packer;

    localparam int BW = 8;
    localparam int R  = 8;
    localparam int C  = 8;
    localparam int BE = 4;
    localparam int NB = R * C / BE;
`ifdef SUB_PACKER_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b1;
    logic [BW-1:0]  src [R-1:0][C-1:0];
    logic [BW-1:0]  cap [R-1:0][C-1:0];
    logic           ir [3];
    logic           ov [3];
    logic           ol [3];
    logic [31:0]    od [3];
    logic [31:0]    exp_beats [3][NB];
    logic [31:0]    got [3][NB];
    int             n_checks = 0;
    int             n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sub_array_stream_packer #(
            .BIT_WIDTH (BW),
            .ROWS      (R),
            .COLS      (C),
            .SUB_ROWS  (g == 0 ? 4 : (g == 1 ? 1 : 8)),
            .BEAT_ELEMS(BE)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (ir[g]),
            .in       (src),
            .out_valid(ov[g]),
            .out_ready(out_ready),
            .out_data (od[g]),
            .out_last (ol[g])
        );
    end

    function automatic int sr_of(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 1 : 8);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: list elements in sub-array order, then cut the list into beats.
    task automatic build();
        logic [BW-1:0] q [$];
        int s;
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) cap[r][c] = src[r][c];
        for (int g = 0; g < 3; g++) begin
            s = sr_of(g);
            q.delete();
            for (int c = 0; c < C; c++) for (int r = 0; r < s; r++) q.push_back(src[r][c]);
            for (int c = 0; c < C; c++) for (int r = s; r < R; r++) q.push_back(src[r][c]);
            for (int b = 0; b < NB; b++) exp_beats[g][b] = {q[4*b+3], q[4*b+2], q[4*b+1], q[4*b]};
        end
    endtask

    task automatic fill_ramp(input bit inv);
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++)
            src[r][c] = inv ? 8'(8'hFF - (r * 8 + c)) : 8'(r * 8 + c);
    endtask

    task automatic fill_rand();
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) src[r][c] = 8'($urandom);
    endtask

    task automatic capture();
        int n;
        n = 0;
        while (ir[0] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("capture_wait", 32'(n < 40), 1);
        build();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int stall_beat, input int stall_len, input bit scramble, input int stop_at);
        for (int b = 0; b < stop_at; b++) begin
            if (b == stall_beat) begin
                out_ready = 1'b0;
                for (int t = 0; t < stall_len; t++) begin
                    for (int g = 0; g < 3; g++) begin
                        check("stall_valid", 32'(ov[g]), 1);
                        check("stall_data", od[g], exp_beats[g][b]);
                        check("stall_last", 32'(ol[g]), 32'(b == NB - 1));
                    end
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            for (int g = 0; g < 3; g++) begin
                check("beat_valid", 32'(ov[g]), 1);
                check("beat_data", od[g], exp_beats[g][b]);
                check("beat_last", 32'(ol[g]), 32'(b == NB - 1));
                check("busy_in_ready", 32'(ir[g]), 32'(OVL && b == NB - 1));
                got[g][b] = od[g];
            end
            if (scramble) begin
                fill_rand();
                in_valid = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (stop_at == NB)
            for (int g = 0; g < 3; g++) begin
                check("done_in_ready", 32'(ir[g]), 1);
                check("done_valid", 32'(ov[g]), 0);
            end
    endtask

    // Unpack the received beats back into an array and compare with what was captured.
    task automatic round_trip();
        logic [BW-1:0] rec [R-1:0][C-1:0];
        int k, s, bad;
        for (int g = 0; g < 3; g++) begin
            s = sr_of(g);
            k = 0;
            for (int c = 0; c < C; c++) for (int r = 0; r < s; r++) begin
                rec[r][c] = got[g][k/4][(k%4)*8 +: 8];
                k++;
            end
            for (int c = 0; c < C; c++) for (int r = s; r < R; r++) begin
                rec[r][c] = got[g][k/4][(k%4)*8 +: 8];
                k++;
            end
            bad = 0;
            for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) if (rec[r][c] !== cap[r][c]) bad++;
            check("round_trip", 32'(bad), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_ramp(1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            check("rst_in_ready", 32'(ir[g]), 1);
            check("rst_valid", 32'(ov[g]), 0);
            check("rst_last", 32'(ol[g]), 0);
            check("rst_data", od[g], 0);
        end

        capture();
        check("beat0_const", od[0], 32'h18100800);
        drain(-1, 0, 1'b0, NB);
        check("beat8_const", got[0][8], 32'h38302820);
        check("beat15_const", got[0][15], 32'h3F372F27);
        round_trip();

        capture();
        drain(5, 3, 1'b0, NB);
        check("stall_beat5_const", got[0][5], 32'h1D150D05);
        round_trip();

        capture();
        drain(-1, 0, 1'b0, 7);
        rst = 1'b1;
        #1;
        for (int g = 0; g < 3; g++) begin
            check("midrst_valid", 32'(ov[g]), 0);
            check("midrst_last", 32'(ol[g]), 0);
            check("midrst_data", od[g], 0);
        end
        @(negedge clk);
        rst = 1'b0;
        fill_ramp(1'b1);
        capture();
        check("inv_beat0_const", od[0], 32'hE7EFF7FF);
        drain(-1, 0, 1'b0, NB);
        round_trip();

        fill_rand();
        capture();
        if (OVL) begin
            drain(-1, 0, 1'b0, NB - 1);
            for (int g = 0; g < 3; g++) begin
                check("ovl_last_data", od[g], exp_beats[g][NB-1]);
                check("ovl_last_flag", 32'(ol[g]), 1);
                check("ovl_in_ready", 32'(ir[g]), 1);
            end
            fill_rand();
            build();
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            drain(-1, 0, 1'b0, NB);
        end else begin
            drain(-1, 0, 1'b0, NB);
            check("gap_valid", 32'(ov[0]), 0);
            fill_rand();
            build();
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            check("no_second_gap", 32'(ov[0]), 1);
            drain(-1, 0, 1'b0, NB);
        end
        round_trip();

        if (!OVL) begin
            fill_ramp(1'b0);
            capture();
            drain(-1, 0, 1'b1, NB);
            round_trip();
        end

        for (int n = 0; n < 20; n++) begin
            fill_rand();
            capture();
            drain(int'($urandom_range(0, NB - 1)), int'($urandom_range(0, 3)), 1'b0, NB);
            round_trip();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
